// File: rtl/bullet_ctrl.sv
// Per-tank bullet controller: launches, steps and retires one bullet per player, then enforces a reload cooldown.
// Latency: state updates land 2 Clk edges after frame_clk rises; every output is registered.
// Backpressure: none; checker verdicts are sampled on tick edges, and fire edges outside IDLE are dropped.
module bullet_ctrl #(
  parameter int STEP_B      = 5,
  parameter int BULLET_SIZE = 8,
  parameter int TANK_SIZE   = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int COOLDOWN    = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] X_Tank,
  input  logic [9:0] Y_Tank,
  input  logic [2:0] facing,
  input  logic [1:0] hit,
  input  logic       target_alive,
  output logic [9:0] X_Bullet,
  output logic [9:0] Y_Bullet,
  output logic [2:0] bullet_dir,
  output logic [9:0] saveX,
  output logic [9:0] saveY,
  output logic       bullet_active,
  output logic       kill
);

  localparam int CNT_W = (COOLDOWN > 255) ? $clog2(COOLDOWN + 1) : 8;

  // Bullet is centred on the tank; edge limits are precomputed so the
  // per-tick comparisons never need a wrapping add.
  localparam logic [9:0]  OFFSET = 10'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [9:0]  STEP   = 10'(STEP_B);
  localparam logic [10:0] LIM_LO = 11'(STEP_B);
  localparam logic [10:0] LIM_X  = 11'(SCREEN_W - BULLET_SIZE - STEP_B);
  localparam logic [10:0] LIM_Y  = 11'(SCREEN_H - BULLET_SIZE - STEP_B);

  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_COOL} state_t;

  state_t     state_q, state_n;
  logic       f1, f2, fire_q, fire_pend, pend_n;
  logic       tick, fire_rise, off_screen;
  logic [9:0] xb_n, yb_n, sx_n, sy_n;
  logic [2:0] dir_n;
  logic       act_n, kill_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  assign tick      = f1 & ~f2;
  assign fire_rise = fire & ~fire_q;

  // Would the pending step carry the bullet past the screen edge?
  always_comb begin
    off_screen = 1'b0;
    case (bullet_dir)
      3'd1:    off_screen = {1'b0, Y_Bullet} < LIM_LO;
      3'd2:    off_screen = {1'b0, X_Bullet} > LIM_X;
      3'd3:    off_screen = {1'b0, X_Bullet} < LIM_LO;
      3'd4:    off_screen = {1'b0, Y_Bullet} > LIM_Y;
      default: off_screen = 1'b0;
    endcase
  end

  // Next-state and next-output logic; everything except the fire latch moves only on tick.
  always_comb begin
    state_n = state_q;
    xb_n    = X_Bullet;
    yb_n    = Y_Bullet;
    sx_n    = saveX;
    sy_n    = saveY;
    dir_n   = bullet_dir;
    act_n   = bullet_active;
    kill_n  = 1'b0;
    cnt_n   = cnt_q;
    pend_n  = fire_pend;

    // A fire edge seen on a tick edge is kept for the following tick.
    if (tick)
      pend_n = fire_rise && (state_q == S_IDLE) && !fire_pend;
    else if (fire_rise && (state_q == S_IDLE))
      pend_n = 1'b1;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (fire_pend && (facing >= 3'd1) && (facing <= 3'd4)) begin
            state_n = S_FLIGHT;
            dir_n   = facing;
            act_n   = 1'b1;
            xb_n    = X_Tank + OFFSET;
            yb_n    = Y_Tank + OFFSET;
            sx_n    = X_Tank;
            sy_n    = Y_Tank;
          end
        end
        S_FLIGHT: begin
          if (!target_alive || (hit == 2'b00) || off_screen) begin
            kill_n  = !target_alive;
            dir_n   = 3'd0;
            act_n   = 1'b0;
            cnt_n   = CNT_W'(COOLDOWN);
            state_n = (COOLDOWN == 0) ? S_IDLE : S_COOL;
          end else begin
            case (bullet_dir)
              3'd1:    yb_n = Y_Bullet - STEP;
              3'd2:    xb_n = X_Bullet + STEP;
              3'd3:    xb_n = X_Bullet - STEP;
              3'd4:    yb_n = Y_Bullet + STEP;
              default: ;
            endcase
          end
        end
        S_COOL: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State register plus tick and fire edge detectors; reset beats tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      f1            <= 1'b0;
      f2            <= 1'b0;
      fire_q        <= 1'b0;
      fire_pend     <= 1'b0;
      X_Bullet      <= '0;
      Y_Bullet      <= '0;
      saveX         <= '0;
      saveY         <= '0;
      bullet_dir    <= '0;
      bullet_active <= 1'b0;
      kill          <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_n;
      f1            <= frame_clk;
      f2            <= f1;
      fire_q        <= fire;
      fire_pend     <= pend_n;
      X_Bullet      <= xb_n;
      Y_Bullet      <= yb_n;
      saveX         <= sx_n;
      saveY         <= sy_n;
      bullet_dir    <= dir_n;
      bullet_active <= act_n;
      kill          <= kill_n;
      cnt_q         <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Scoreboard bench for bullet_ctrl: stimulus queues every expected output snapshot,
// the monitor pops one whenever the DUT's outputs change and compares.
module tb_bullet_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, fire, target_alive;
  logic [9:0] X_Tank, Y_Tank;
  logic [2:0] facing;
  logic [1:0] hit;
  logic [9:0] X_Bullet, Y_Bullet, saveX, saveY;
  logic [2:0] bullet_dir;
  logic       bullet_active, kill;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] dir;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       act;
    logic       kill;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur;
  logic  mon_en = 1'b0;
  logic  done   = 1'b0;
  int    checks = 0;
  int    errors = 0;

  assign cur = '{X_Bullet, Y_Bullet, bullet_dir, saveX, saveY, bullet_active, kill};

  bullet_ctrl #(.COOLDOWN(3)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .X_Tank(X_Tank), .Y_Tank(Y_Tank), .facing(facing), .hit(hit),
    .target_alive(target_alive), .X_Bullet(X_Bullet), .Y_Bullet(Y_Bullet),
    .bullet_dir(bullet_dir), .saveX(saveX), .saveY(saveY),
    .bullet_active(bullet_active), .kill(kill)
  );

  always #5 Clk = ~Clk;

  function automatic string fmt(input snap_t s);
    return $sformatf("x=%0d y=%0d dir=%0d sx=%0d sy=%0d act=%0d kill=%0d",
                     s.x, s.y, s.dir, s.sx, s.sy, s.act, s.kill);
  endfunction

  task automatic push(input int x, input int y, input int dir, input int sx,
                      input int sy, input int act, input int k);
    snap_t s;
    s.x = 10'(x); s.y = 10'(y); s.dir = 3'(dir);
    s.sx = 10'(sx); s.sy = 10'(sy); s.act = 1'(act); s.kill = 1'(k);
    exp_q.push_back(s);
  endtask

  task automatic fire_pulse();
    @(negedge Clk); fire = 1'b1;
    repeat (2) @(negedge Clk);
    fire = 1'b0;
  endtask

  task automatic frame();
    @(negedge Clk); frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  // Monitor: every output change consumes one expected snapshot.
  initial begin
    snap_t prev, e;
    wait (mon_en);
    checks++;
    if (cur !== snap_t'(0)) begin
      errors++;
      $display("FAIL reset_state got %s want all zero", fmt(cur));
    end
    prev = cur;
    while (!done) begin
      @(negedge Clk);
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got %s want no change", fmt(cur));
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL snapshot_%0d got %s want %s", checks, fmt(cur), fmt(e));
          end
        end
        prev = cur;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_changes got %0d pending want 0, next %s", exp_q.size(), fmt(exp_q[0]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    Reset = 1'b1; frame_clk = 1'b0; fire = 1'b0; target_alive = 1'b1;
    hit = 2'b11; X_Tank = '0; Y_Tank = '0; facing = 3'd0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge Clk);

    // Launch right from (100,200), then three steps.
    X_Tank = 10'd100; Y_Tank = 10'd200; facing = 3'd2;
    push(112, 212, 2, 100, 200, 1, 0);
    fire_pulse(); frame();
    push(117, 212, 2, 100, 200, 1, 0); frame();
    push(122, 212, 2, 100, 200, 1, 0); frame();
    push(127, 212, 2, 100, 200, 1, 0); frame();

    // Wall hit retires; fire edges during the three cooldown ticks are dropped.
    hit = 2'b00;
    push(127, 212, 0, 100, 200, 0, 0); frame();
    hit = 2'b11;
    for (int i = 0; i < 3; i++) begin
      fire_pulse(); frame();
    end

    // Fresh fire after cooldown, facing up from (100,0); tank moves mid-flight.
    X_Tank = 10'd100; Y_Tank = 10'd0; facing = 3'd1;
    push(112, 12, 1, 100, 0, 1, 0);
    fire_pulse(); frame();
    X_Tank = 10'd500; facing = 3'd2;
    push(112, 7, 1, 100, 0, 1, 0); frame();
    push(112, 2, 1, 100, 0, 1, 0); frame();
    push(112, 2, 0, 100, 0, 0, 0); frame();
    repeat (3) frame();

    // Tank hit with simultaneous wall hit: one retirement, one-cycle kill.
    X_Tank = 10'd300; Y_Tank = 10'd100; facing = 3'd3;
    push(312, 112, 3, 300, 100, 1, 0);
    fire_pulse(); frame();
    push(307, 112, 3, 300, 100, 1, 0); frame();
    target_alive = 1'b0; hit = 2'b00;
    push(307, 112, 0, 300, 100, 0, 1);
    push(307, 112, 0, 300, 100, 0, 0);
    frame();
    target_alive = 1'b1; hit = 2'b11;
    repeat (3) frame();

    // Invalid facing: no launch, and the pending fire is gone by the next tick.
    facing = 3'd0;
    fire_pulse(); frame();
    facing = 3'd4; X_Tank = 10'd200; Y_Tank = 10'd440;
    frame();

    // Held fire across 10 ticks: one launch down, stops exactly at the bottom limit.
    fire = 1'b1;
    push(212, 452, 4, 200, 440, 1, 0);
    push(212, 457, 4, 200, 440, 1, 0);
    push(212, 462, 4, 200, 440, 1, 0);
    push(212, 467, 4, 200, 440, 1, 0);
    push(212, 472, 4, 200, 440, 1, 0);
    push(212, 472, 0, 200, 440, 0, 0);
    repeat (10) frame();
    fire = 1'b0;

    // Reset mid-flight at X=300.
    X_Tank = 10'd288; Y_Tank = 10'd100; facing = 3'd2;
    push(300, 112, 2, 288, 100, 1, 0);
    fire_pulse(); frame();
    push(0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    frame(); frame();

    repeat (4) @(negedge Clk);
    done = 1'b1;
  end

endmodule
